// File: rtl/johnson_monitor_if.sv
// Bus between the Johnson counter side and johnson_monitor.
//   count_in   Johnson counter parallel output (asynchronous to the monitor clock)
//   clear_err  synchronous pulse that clears the sticky step error
//   index      decoded step index 0..2*WIDTH-1
//   legal      last sampled code was a valid Johnson code
//   change     one-cycle pulse per evaluated change
//   step_err   sticky error flag
//   rev_count  completed revolutions, wraps
//   hex_out    active-low 7-segment pattern {g,f,e,d,c,b,a} of index
// master drives count_in/clear_err; slave is the monitor.
interface johnson_monitor_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8
);
  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] count_in;
  logic             clear_err;
  logic [IW-1:0]    index;
  logic             legal;
  logic             change;
  logic             step_err;
  logic [REV_W-1:0] rev_count;
  logic [6:0]       hex_out;

  modport master (
    output count_in,
    output clear_err,
    input  index,
    input  legal,
    input  change,
    input  step_err,
    input  rev_count,
    input  hex_out
  );

  modport slave (
    input  count_in,
    input  clear_err,
    output index,
    output legal,
    output change,
    output step_err,
    output rev_count,
    output hex_out
  );
endinterface

// File: rtl/johnson_monitor.sv
// Johnson counter monitor. Synchronises the Johnson count into the clk domain, decodes it to a
// step index, checks each change for a legal code and a legal successor (sticky step_err),
// counts completed revolutions and drives an active-low 7-segment pattern of the index.
// Ports:
//   clk    system clock (CLOCK_50)
//   reset  asynchronous active-high reset, clears all state
//   bus    johnson_monitor_if slave: count_in, clear_err in; index, legal, change, step_err,
//          rev_count, hex_out out
// Latency from a count_in edge to the registered outputs is 3 clk.
module johnson_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8
) (
  input logic              clk,
  input logic              reset,
  johnson_monitor_if.slave bus
);
  localparam int unsigned IW        = $clog2(2 * WIDTH);
  localparam int unsigned NumStates = 2 * WIDTH;
  localparam logic [IW-1:0]    LastIdx = IW'(NumStates - 1);
  localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);

  // s1/s2 form the synchroniser; s3 holds the previously evaluated value.
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  logic [IW-1:0]    index_q, index_d;
  logic             legal_q, legal_d;
  logic             change_q, change_d;
  logic             err_q, err_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             primed_q, primed_d;

  logic [WIDTH-1:0] inv_code;
  logic             lo_block, hi_block, code_legal;
  int unsigned      pop;
  logic [IW-1:0]    code_idx, succ_idx;
  logic             err_set;
  logic [3:0]       hex_sel;
  logic [6:0]       hex_pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      index_q  <= '0;
      legal_q  <= 1'b0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      rev_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      s1_q     <= bus.count_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      index_q  <= index_d;
      legal_q  <= legal_d;
      change_q <= change_d;
      err_q    <= err_d;
      rev_q    <= rev_d;
      primed_q <= primed_d;
    end
  end

  // Decode: a legal code is a single run of ones anchored at bit 0 (x & (x+1) == 0) or at the
  // MSB (same test on the inverted code). All-zero and all-one satisfy both.
  always_comb begin
    inv_code   = ~s2_q;
    lo_block   = ((s2_q & (s2_q + OneW)) == '0);
    hi_block   = ((inv_code & (inv_code + OneW)) == '0);
    code_legal = lo_block | hi_block;

    pop = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i]) pop = pop + 1;
    end
    code_idx = s2_q[WIDTH-1] ? IW'(NumStates - pop) : IW'(pop);
    succ_idx = (index_q == LastIdx) ? '0 : index_q + IW'(1);
  end

  always_comb begin
    index_d  = index_q;
    legal_d  = legal_q;
    change_d = 1'b0;
    rev_d    = rev_q;
    primed_d = primed_q;
    err_set  = 1'b0;

    if (s2_q != s3_q) begin
      change_d = 1'b1;
      if (code_legal) begin
        index_d  = code_idx;
        legal_d  = 1'b1;
        primed_d = 1'b1;
        // An unprimed evaluation only establishes the reference point.
        if (primed_q) begin
          if (code_idx == succ_idx) begin
            if (index_q == LastIdx) rev_d = rev_q + REV_W'(1);
          end else begin
            err_set = 1'b1;
          end
        end
      end else begin
        // Index holds the last legal value; the next legal code re-primes.
        legal_d  = 1'b0;
        primed_d = 1'b0;
        err_set  = 1'b1;
      end
    end

    // A new error wins over a coincident clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Active-low segments {g,f,e,d,c,b,a}.
  always_comb begin
    hex_sel = 4'(index_q);
    hex_pat = 7'b1000000;
    case (hex_sel)
      4'h0: hex_pat = 7'b1000000;
      4'h1: hex_pat = 7'b1111001;
      4'h2: hex_pat = 7'b0100100;
      4'h3: hex_pat = 7'b0110000;
      4'h4: hex_pat = 7'b0011001;
      4'h5: hex_pat = 7'b0010010;
      4'h6: hex_pat = 7'b0000010;
      4'h7: hex_pat = 7'b1111000;
      4'h8: hex_pat = 7'b0000000;
      4'h9: hex_pat = 7'b0010000;
      4'hA: hex_pat = 7'b0001000;
      4'hB: hex_pat = 7'b0000011;
      4'hC: hex_pat = 7'b1000110;
      4'hD: hex_pat = 7'b0100001;
      4'hE: hex_pat = 7'b0000110;
      4'hF: hex_pat = 7'b0001110;
      default: hex_pat = 7'b1000000;
    endcase
  end

  assign bus.index     = index_q;
  assign bus.legal     = legal_q;
  assign bus.change    = change_q;
  assign bus.step_err  = err_q;
  assign bus.rev_count = rev_q;
  assign bus.hex_out   = hex_pat;
endmodule

// File: tb/tb_johnson_monitor.sv
// Directed testbench for johnson_monitor (WIDTH=4, REV_W=8).
module tb_johnson_monitor;
  logic CLOCK_50;
  logic reset;
  int   total;
  int   bad;

  johnson_monitor_if #(.WIDTH(4), .REV_W(8)) bus ();

  johnson_monitor #(.WIDTH(4), .REV_W(8)) dut (
    .clk   (CLOCK_50),
    .reset (reset),
    .bus   (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Drive a new code at a falling edge, then let it settle for the given number of cycles.
  task automatic apply(input logic [3:0] code, input int cycles);
    @(negedge CLOCK_50);
    bus.count_in = code;
    repeat (cycles) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.count_in = 4'b0000;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    apply(4'b0001, 5);
    apply(4'b0011, 5);
    apply(4'b1111, 5);  // skip: index 4, error set
    total++;
    if (bus.index !== 3'd4 || bus.step_err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state index=%0d err=%b need index=4 err=1", bus.index,
               bus.step_err);
    end
    @(negedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    total++;
    if (bus.index !== 3'd0) begin
      bad++; $display("FAIL reset_index got %0d need 0", bus.index);
    end
    total++;
    if (bus.legal !== 1'b0) begin
      bad++; $display("FAIL reset_legal got %b need 0", bus.legal);
    end
    total++;
    if (bus.change !== 1'b0) begin
      bad++; $display("FAIL reset_change got %b need 0", bus.change);
    end
    total++;
    if (bus.step_err !== 1'b0) begin
      bad++; $display("FAIL reset_err got %b need 0", bus.step_err);
    end
    total++;
    if (bus.rev_count !== 8'd0) begin
      bad++; $display("FAIL reset_rev got %0d need 0", bus.rev_count);
    end
    total++;
    if (bus.hex_out !== 7'b1000000) begin
      bad++; $display("FAIL reset_hex got %b need 1000000", bus.hex_out);
    end
  endtask

  task automatic test_prime();
    bus.count_in = 4'b0000;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    total++;
    if (bus.change !== 1'b0 || bus.index !== 3'd0 || bus.legal !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset change=%b index=%0d legal=%b need 0 0 0", bus.change,
               bus.index, bus.legal);
    end
    @(negedge CLOCK_50);
    bus.count_in = 4'b0001;
    repeat (2) @(negedge CLOCK_50);
    total++;
    if (bus.change !== 1'b0 || bus.index !== 3'd0) begin
      bad++;
      $display("FAIL latency_early change=%b index=%0d need 0 0", bus.change, bus.index);
    end
    @(negedge CLOCK_50);
    total++;
    if (bus.index !== 3'd1 || bus.legal !== 1'b1) begin
      bad++;
      $display("FAIL prime_index index=%0d legal=%b need 1 1", bus.index, bus.legal);
    end
    total++;
    if (bus.change !== 1'b1) begin
      bad++; $display("FAIL prime_change got %b need 1", bus.change);
    end
    total++;
    if (bus.step_err !== 1'b0) begin
      bad++; $display("FAIL prime_err got %b need 0", bus.step_err);
    end
    total++;
    if (bus.hex_out !== 7'b1111001) begin
      bad++; $display("FAIL prime_hex got %b need 1111001", bus.hex_out);
    end
    @(negedge CLOCK_50);
    total++;
    if (bus.change !== 1'b0) begin
      bad++; $display("FAIL change_width got %b need 0", bus.change);
    end
    repeat (6) @(negedge CLOCK_50);
  endtask

  task automatic test_walk();
    logic [3:0] codes [7] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] idxs  [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [6:0] hexes [7] = '{7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
                              7'b1111000, 7'b1000000};
    logic [7:0] revs  [7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 7; i++) begin
      apply(codes[i], 10);
      total++;
      if (bus.index !== idxs[i] || bus.hex_out !== hexes[i]) begin
        bad++;
        $display("FAIL walk_index step %0d index=%0d hex=%b need %0d %b", i, bus.index,
                 bus.hex_out, idxs[i], hexes[i]);
      end
      total++;
      if (bus.rev_count !== revs[i] || bus.step_err !== 1'b0) begin
        bad++;
        $display("FAIL walk_rev step %0d rev=%0d err=%b need %0d 0", i, bus.rev_count,
                 bus.step_err, revs[i]);
      end
    end
  endtask

  task automatic test_skip();
    apply(4'b0001, 10);
    apply(4'b0011, 10);
    apply(4'b1111, 10);
    total++;
    if (bus.index !== 3'd4 || bus.legal !== 1'b1) begin
      bad++;
      $display("FAIL skip_index index=%0d legal=%b need 4 1", bus.index, bus.legal);
    end
    total++;
    if (bus.step_err !== 1'b1 || bus.rev_count !== 8'd1) begin
      bad++;
      $display("FAIL skip_err err=%b rev=%0d need 1 1", bus.step_err, bus.rev_count);
    end
  endtask

  task automatic test_illegal();
    apply(4'b0101, 10);
    total++;
    if (bus.legal !== 1'b0 || bus.step_err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_flag legal=%b err=%b need 0 1", bus.legal, bus.step_err);
    end
    total++;
    if (bus.index !== 3'd4 || bus.hex_out !== 7'b0011001) begin
      bad++;
      $display("FAIL illegal_hold index=%0d hex=%b need 4 0011001", bus.index, bus.hex_out);
    end
  endtask

  task automatic test_clear_err();
    @(negedge CLOCK_50);
    bus.clear_err = 1'b1;
    @(negedge CLOCK_50);
    bus.clear_err = 1'b0;
    total++;
    if (bus.step_err !== 1'b0 || bus.index !== 3'd4) begin
      bad++;
      $display("FAIL clear_err err=%b index=%0d need 0 4", bus.step_err, bus.index);
    end
  endtask

  task automatic test_reprime();
    apply(4'b0011, 10);
    total++;
    if (bus.index !== 3'd2 || bus.legal !== 1'b1 || bus.step_err !== 1'b0) begin
      bad++;
      $display("FAIL reprime index=%0d legal=%b err=%b need 2 1 0", bus.index, bus.legal,
               bus.step_err);
    end
  endtask

  task automatic test_clear_coincident();
    @(negedge CLOCK_50);
    bus.count_in = 4'b1111;
    repeat (2) @(negedge CLOCK_50);
    bus.clear_err = 1'b1;  // high across the evaluating edge
    @(negedge CLOCK_50);
    bus.clear_err = 1'b0;
    total++;
    if (bus.change !== 1'b1 || bus.index !== 3'd4) begin
      bad++;
      $display("FAIL coincide_eval change=%b index=%0d need 1 4", bus.change, bus.index);
    end
    total++;
    if (bus.step_err !== 1'b1) begin
      bad++; $display("FAIL coincide_err got %b need 1", bus.step_err);
    end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] seq [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000,
                            4'b0001};
    @(negedge CLOCK_50);
    reset = 1'b1;
    bus.count_in = 4'b0000;
    @(negedge CLOCK_50);
    reset = 1'b0;
    apply(4'b0001, 5);
    for (int r = 0; r < 256; r++) begin
      for (int s = 0; s < 8; s++) apply(seq[s], 4);
      if (r == 0) begin
        total++;
        if (bus.rev_count !== 8'd1) begin
          bad++; $display("FAIL wrap_first got %0d need 1", bus.rev_count);
        end
      end
      if (r == 254) begin
        total++;
        if (bus.rev_count !== 8'd255) begin
          bad++; $display("FAIL wrap_255 got %0d need 255", bus.rev_count);
        end
      end
    end
    total++;
    if (bus.rev_count !== 8'd0) begin
      bad++; $display("FAIL wrap_zero got %0d need 0", bus.rev_count);
    end
    total++;
    if (bus.step_err !== 1'b0 || bus.index !== 3'd1) begin
      bad++;
      $display("FAIL wrap_clean err=%b index=%0d need 0 1", bus.step_err, bus.index);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_prime();
    test_walk();
    test_skip();
    test_illegal();
    test_clear_err();
    test_reprime();
    test_clear_coincident();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
